calc_seq_ctrl: RTL and testbench

Parametrised control sequencer for the keypad calculator: takes key-event pulses, and drives operand entry, operator latching, ALU start and result write-back to the operand/ALU datapath. It sits between the keypad decoder and the operand registers/ALU. It replaces the fixed 4-digit controller with an internal digit counter, configurable digit limit and operator width, and chained operations. It also adds repeat-equals and an ALU error state.

---
 rtl/calc_seq_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_calc_seq_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/calc_seq_ctrl.sv
// Keypad calculator control sequencer: turns key-event pulses into operand,
// operator and ALU control strobes, with operation chaining, repeat-equals and an error state.
module calc_seq_ctrl #(
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned OPW        = 2,
  localparam int unsigned CNTW      = $clog2(MAX_DIGITS + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              num,
  input  logic              op,
  input  logic [OPW-1:0]    op_in,
  input  logic              c,
  input  logic              eq,
  input  logic              alu_done,
  input  logic              alu_err,
  output logic              a_clr,
  output logic              a_wr,
  output logic              b_clr,
  output logic              b_wr,
  output logic              alu_start,
  output logic              res_wr,
  output logic              clr,
  output logic [OPW-1:0]    op_code,
  output logic [1:0]        disp_sel,
  output logic              err,
  output logic [CNTW-1:0]   digit_cnt,
  output logic [2:0]        state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ENTER_A = 3'd1;
  localparam logic [2:0] S_OP_WAIT = 3'd2;
  localparam logic [2:0] S_ENTER_B = 3'd3;
  localparam logic [2:0] S_EXEC    = 3'd4;
  localparam logic [2:0] S_RESULT  = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;

  localparam logic [CNTW-1:0] MAX_CNT = CNTW'(MAX_DIGITS);
  localparam logic [CNTW-1:0] ONE_CNT = CNTW'(1);

  logic [2:0]      state_q, state_nxt;
  logic [CNTW-1:0] cnt_q, cnt_nxt;
  logic [OPW-1:0]  op_code_q, op_code_nxt;
  logic [OPW-1:0]  pend_q, pend_nxt;
  logic            chain_q, chain_nxt;

  logic a_clr_nxt, a_wr_nxt, b_clr_nxt, b_wr_nxt;
  logic alu_start_nxt, res_wr_nxt, clr_nxt, err_nxt;
  logic [1:0] disp_nxt;

  // Key priority c > eq > op > num; lower-priority keys in the same cycle are dropped.
  logic ev_eq, ev_op, ev_num, cnt_room;
  assign ev_eq    = eq & ~c;
  assign ev_op    = op & ~c & ~eq;
  assign ev_num   = num & ~c & ~eq & ~op;
  assign cnt_room = (cnt_q < MAX_CNT);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_code_q <= '0;
      pend_q    <= '0;
      chain_q   <= 1'b0;
      a_clr     <= 1'b0;
      a_wr      <= 1'b0;
      b_clr     <= 1'b0;
      b_wr      <= 1'b0;
      alu_start <= 1'b0;
      res_wr    <= 1'b0;
      clr       <= 1'b0;
      disp_sel  <= 2'b00;
      err       <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      op_code_q <= op_code_nxt;
      pend_q    <= pend_nxt;
      chain_q   <= chain_nxt;
      a_clr     <= a_clr_nxt;
      a_wr      <= a_wr_nxt;
      b_clr     <= b_clr_nxt;
      b_wr      <= b_wr_nxt;
      alu_start <= alu_start_nxt;
      res_wr    <= res_wr_nxt;
      clr       <= clr_nxt;
      disp_sel  <= disp_nxt;
      err       <= err_nxt;
    end
  end

  // Next state, digit counter, operator latch and chaining bookkeeping.
  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    op_code_nxt = op_code_q;
    pend_nxt    = pend_q;
    chain_nxt   = chain_q;
    if (c) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      chain_nxt = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ev_num) begin
            state_nxt = S_ENTER_A;
            cnt_nxt   = ONE_CNT;
          end
        end
        S_ENTER_A: begin
          if (ev_op) begin
            op_code_nxt = op_in;
            cnt_nxt     = '0;
            state_nxt   = S_OP_WAIT;
          end else if (ev_num && cnt_room) begin
            cnt_nxt = cnt_q + ONE_CNT;
          end
        end
        S_OP_WAIT: begin
          if (ev_op) begin
            op_code_nxt = op_in;
          end else if (ev_num) begin
            cnt_nxt   = ONE_CNT;
            state_nxt = S_ENTER_B;
          end
        end
        S_ENTER_B: begin
          if (ev_eq) begin
            chain_nxt = 1'b0;
            state_nxt = S_EXEC;
          end else if (ev_op) begin
            pend_nxt  = op_in;
            chain_nxt = 1'b1;
            state_nxt = S_EXEC;
          end else if (ev_num && cnt_room) begin
            cnt_nxt = cnt_q + ONE_CNT;
          end
        end
        S_EXEC: begin
          if (alu_done) begin
            if (alu_err) begin
              state_nxt = S_ERROR;
            end else if (chain_q) begin
              op_code_nxt = pend_q;
              chain_nxt   = 1'b0;
              cnt_nxt     = '0;
              state_nxt   = S_OP_WAIT;
            end else begin
              state_nxt = S_RESULT;
            end
          end
        end
        S_RESULT: begin
          if (ev_eq) begin
            state_nxt = S_EXEC;
          end else if (ev_op) begin
            op_code_nxt = op_in;
            cnt_nxt     = '0;
            state_nxt   = S_OP_WAIT;
          end else if (ev_num) begin
            cnt_nxt   = ONE_CNT;
            state_nxt = S_ENTER_A;
          end
        end
        S_ERROR: ;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Strobe and display values for the next cycle.
  always_comb begin
    a_clr_nxt     = 1'b0;
    a_wr_nxt      = 1'b0;
    b_clr_nxt     = 1'b0;
    b_wr_nxt      = 1'b0;
    alu_start_nxt = 1'b0;
    res_wr_nxt    = 1'b0;
    clr_nxt       = 1'b0;
    disp_nxt      = 2'b00;
    err_nxt       = 1'b0;
    if (c) begin
      clr_nxt = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          a_clr_nxt = ev_num;
          a_wr_nxt  = ev_num;
        end
        S_ENTER_A: a_wr_nxt = ev_num & cnt_room;
        S_OP_WAIT: begin
          b_clr_nxt = ev_num;
          b_wr_nxt  = ev_num;
        end
        S_ENTER_B: begin
          alu_start_nxt = ev_eq | ev_op;
          b_wr_nxt      = ev_num & cnt_room;
        end
        S_EXEC:    res_wr_nxt = alu_done & ~alu_err;
        S_RESULT: begin
          alu_start_nxt = ev_eq;
          a_clr_nxt     = ev_num;
          a_wr_nxt      = ev_num;
        end
        default: ;
      endcase
    end
    case (state_nxt)
      S_ENTER_A, S_RESULT: disp_nxt = 2'b01;
      S_OP_WAIT:           disp_nxt = 2'b10;
      S_ENTER_B, S_EXEC:   disp_nxt = 2'b11;
      S_ERROR:             err_nxt  = 1'b1;
      default: ;
    endcase
  end

  assign op_code   = op_code_q;
  assign digit_cnt = cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed, table-driven bench for calc_seq_ctrl (MAX_DIGITS=4, OPW=2).
module tb_calc_seq_ctrl;

  logic clk = 1'b0;
  logic resetn, num, op, c, eq, alu_done, alu_err;
  logic [1:0] op_in;
  logic a_clr, a_wr, b_clr, b_wr, alu_start, res_wr, clr, err;
  logic [1:0] op_code, disp_sel;
  logic [2:0] digit_cnt, state;

  int checks = 0;
  int errors = 0;

  calc_seq_ctrl #(.MAX_DIGITS(4), .OPW(2)) dut (
    .clk(clk), .resetn(resetn), .num(num), .op(op), .op_in(op_in), .c(c), .eq(eq),
    .alu_done(alu_done), .alu_err(alu_err),
    .a_clr(a_clr), .a_wr(a_wr), .b_clr(b_clr), .b_wr(b_wr), .alu_start(alu_start),
    .res_wr(res_wr), .clr(clr), .op_code(op_code), .disp_sel(disp_sel), .err(err),
    .digit_cnt(digit_cnt), .state(state)
  );

  always #5 clk = ~clk;

  // Input bits {rst, num, op, c, eq, alu_done, alu_err}
  localparam logic [6:0] Z = 7'b0000000, R = 7'b1000000, N = 7'b0100000, O = 7'b0010000;
  localparam logic [6:0] C = 7'b0001000, E = 7'b0000100, D = 7'b0000010, X = 7'b0000001;
  // Pulse bits {a_clr, a_wr, b_clr, b_wr, alu_start, res_wr, clr}
  localparam logic [6:0] P0 = 7'b0000000, PAL = 7'b1100000, PAW = 7'b0100000, PBL = 7'b0011000;
  localparam logic [6:0] PBW = 7'b0001000, PS = 7'b0000100, PR = 7'b0000010, PC = 7'b0000001;

  typedef struct {
    logic [6:0] in;
    logic [1:0] oi;
    logic [2:0] st;
    logic [6:0] p;
    logic [1:0] opc;
    logic [1:0] disp;
    logic       e;
    logic [2:0] cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [6:0] i, input logic [1:0] oi, input logic [2:0] st,
                              input logic [6:0] p, input logic [1:0] opc, input logic [1:0] d,
                              input logic e, input logic [2:0] cnt);
    vec_t v;
    v.in = i; v.oi = oi; v.st = st; v.p = p; v.opc = opc; v.disp = d; v.e = e; v.cnt = cnt;
    return v;
  endfunction

  function automatic logic [17:0] obs();
    return {state, a_clr, a_wr, b_clr, b_wr, alu_start, res_wr, clr, op_code, disp_sel, err, digit_cnt};
  endfunction

  task automatic apply(input logic [6:0] i, input logic [1:0] oi);
    @(negedge clk);
    resetn = ~i[6]; num = i[5]; op = i[4]; c = i[3]; eq = i[2];
    alu_done = i[1]; alu_err = i[0]; op_in = oi;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [17:0] exp;
    resetn = 1'b0; num = 0; op = 0; c = 0; eq = 0; alu_done = 0; alu_err = 0; op_in = 2'd0;

    // Digit entry on A with saturation at 4
    vq.push_back(mk(N, 0, 1, PAL, 0, 1, 0, 1));
    vq.push_back(mk(N, 0, 1, PAW, 0, 1, 0, 2));
    vq.push_back(mk(N, 0, 1, PAW, 0, 1, 0, 3));
    vq.push_back(mk(N, 0, 1, PAW, 0, 1, 0, 4));
    vq.push_back(mk(N, 0, 1, P0,  0, 1, 0, 4));
    vq.push_back(mk(E, 0, 1, P0,  0, 1, 0, 4));
    // Operator latch, eq ignored in OP_WAIT, operator replacement
    vq.push_back(mk(O, 2, 2, P0,  2, 2, 0, 0));
    vq.push_back(mk(E, 0, 2, P0,  2, 2, 0, 0));
    vq.push_back(mk(O, 1, 2, P0,  1, 2, 0, 0));
    vq.push_back(mk(O, 2, 2, P0,  2, 2, 0, 0));
    vq.push_back(mk(N, 0, 3, PBL, 2, 3, 0, 1));
    // eq, ALU done three cycles later
    vq.push_back(mk(E, 0, 4, PS,  2, 3, 0, 1));
    vq.push_back(mk(Z, 0, 4, P0,  2, 3, 0, 1));
    vq.push_back(mk(Z, 0, 4, P0,  2, 3, 0, 1));
    vq.push_back(mk(D, 0, 5, PR,  2, 1, 0, 1));
    vq.push_back(mk(Z, 0, 5, P0,  2, 1, 0, 1));
    // Repeat-equals twice
    vq.push_back(mk(E, 0, 4, PS,  2, 3, 0, 1));
    vq.push_back(mk(D, 0, 5, PR,  2, 1, 0, 1));
    vq.push_back(mk(E, 0, 4, PS,  2, 3, 0, 1));
    vq.push_back(mk(D, 0, 5, PR,  2, 1, 0, 1));
    // New calculation with chained operator
    vq.push_back(mk(N, 0, 1, PAL, 2, 1, 0, 1));
    vq.push_back(mk(O, 1, 2, P0,  1, 2, 0, 0));
    vq.push_back(mk(N, 0, 3, PBL, 1, 3, 0, 1));
    vq.push_back(mk(N, 0, 3, PBW, 1, 3, 0, 2));
    vq.push_back(mk(O, 3, 4, PS,  1, 3, 0, 2));
    vq.push_back(mk(D, 0, 2, PR,  3, 2, 0, 0));
    // ALU error, inputs ignored, clear
    vq.push_back(mk(N, 0, 3, PBL, 3, 3, 0, 1));
    vq.push_back(mk(E, 0, 4, PS,  3, 3, 0, 1));
    vq.push_back(mk(D|X, 0, 6, P0, 3, 0, 1, 1));
    vq.push_back(mk(N, 0, 6, P0,  3, 0, 1, 1));
    vq.push_back(mk(O, 1, 6, P0,  3, 0, 1, 1));
    vq.push_back(mk(E, 0, 6, P0,  3, 0, 1, 1));
    vq.push_back(mk(D, 0, 6, P0,  3, 0, 1, 1));
    vq.push_back(mk(C, 0, 0, PC,  3, 0, 0, 0));
    vq.push_back(mk(D, 0, 0, P0,  3, 0, 0, 0));
    vq.push_back(mk(O, 1, 0, P0,  3, 0, 0, 0));
    vq.push_back(mk(E, 0, 0, P0,  3, 0, 0, 0));
    // c and eq together in ENTER_B
    vq.push_back(mk(N, 0, 1, PAL, 3, 1, 0, 1));
    vq.push_back(mk(O, 0, 2, P0,  0, 2, 0, 0));
    vq.push_back(mk(N, 0, 3, PBL, 0, 3, 0, 1));
    vq.push_back(mk(C|E, 0, 0, PC, 0, 0, 0, 0));
    // c coinciding with alu_done in EXEC
    vq.push_back(mk(N, 0, 1, PAL, 0, 1, 0, 1));
    vq.push_back(mk(O, 2, 2, P0,  2, 2, 0, 0));
    vq.push_back(mk(N, 0, 3, PBL, 2, 3, 0, 1));
    vq.push_back(mk(E, 0, 4, PS,  2, 3, 0, 1));
    vq.push_back(mk(C|D, 0, 0, PC, 2, 0, 0, 0));
    vq.push_back(mk(D, 0, 0, P0,  2, 0, 0, 0));
    // Key priority: op over num, eq over op
    vq.push_back(mk(N, 0, 1, PAL, 2, 1, 0, 1));
    vq.push_back(mk(O|N, 1, 2, P0, 1, 2, 0, 0));
    vq.push_back(mk(O|N, 3, 2, P0, 3, 2, 0, 0));
    vq.push_back(mk(N, 0, 3, PBL, 3, 3, 0, 1));
    vq.push_back(mk(E|O, 0, 4, PS, 3, 3, 0, 1));
    vq.push_back(mk(D, 0, 5, PR,  3, 1, 0, 1));
    vq.push_back(mk(O, 2, 2, P0,  2, 2, 0, 0));
    // Reset during EXEC, later alu_done ignored
    vq.push_back(mk(N, 0, 3, PBL, 2, 3, 0, 1));
    vq.push_back(mk(E, 0, 4, PS,  2, 3, 0, 1));
    vq.push_back(mk(R, 0, 0, P0,  0, 0, 0, 0));
    vq.push_back(mk(D, 0, 0, P0,  0, 0, 0, 0));

    // Two reset cycles, then everything must be zero
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state_outputs", int'(obs()), 0);

    foreach (vq[k]) begin
      apply(vq[k].in, vq[k].oi);
      exp = {vq[k].st, vq[k].p, vq[k].opc, vq[k].disp, vq[k].e, vq[k].cnt};
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL vec%0d {st,pulses,opc,disp,err,cnt} got=%b exp=%b", k, obs(), exp);
      end
    end

    // Longer ALU latency: EXEC holds quietly until alu_done, then res_wr next cycle
    apply(N, 0);
    apply(O, 3);
    apply(N, 0);
    apply(E, 0);
    chk("lat_alu_start", int'(alu_start), 1);
    chk("lat_exec_state", int'(state), 4);
    for (int i = 0; i < 5; i++) begin
      apply(Z, 0);
      chk($sformatf("lat_wait%0d", i), int'({state, alu_start, res_wr}), 4 << 2);
    end
    apply(D, 0);
    chk("lat_res_wr", int'(res_wr), 1);
    chk("lat_result_state", int'(state), 5);
    chk("lat_disp", int'(disp_sel), 1);
    chk("lat_op_code", int'(op_code), 3);
    apply(Z, 0);
    chk("lat_res_wr_one_cycle", int'(res_wr), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
